// File: rtl/rot_cell_wide.sv
// Rotatable WIDTH-bit logic cell with a DEPTH-stage register pipeline on the top->left path.
// Define ROT_CELL_WIDE_SCAN_EN to add a serial scan chain through the pipeline bits.
module rot_cell_wide #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trig,
    input  logic             load,
    input  logic [1:0]       load_rot,
    input  logic [WIDTH-1:0] in_t,
    input  logic [WIDTH-1:0] in_r,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_l,
    input  logic [WIDTH-1:0] in_i,
    input  logic             en_i,
`ifdef ROT_CELL_WIDE_SCAN_EN
    input  logic             scan_en,
    input  logic             scan_in,
    output logic             scan_out,
`endif
    output logic [WIDTH-1:0] out_t,
    output logic [WIDTH-1:0] out_r,
    output logic [WIDTH-1:0] out_b,
    output logic [WIDTH-1:0] out_l,
    output logic [WIDTH-1:0] out_o,
    output logic [1:0]       rot_o
);

    localparam int NBITS = WIDTH * DEPTH;

    logic [1:0]       rot_q, rot_d;
    logic [NBITS-1:0] pipe_q, pipe_d, normal_d;
    logic [WIDTH-1:0] x_t, x_r, x_b, x_l;
    logic [WIDTH-1:0] t_out, rb_out, l_out;

    always_comb begin
        rot_d = rot_q;
        if (load)
            rot_d = load_rot;
        else if (trig)
            rot_d = rot_q + 2'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rot_q <= 2'd0;
        else
            rot_q <= rot_d;
    end

    // Physical edges are mapped onto the upright logical cell.
    always_comb begin
        x_t = in_t;
        x_r = in_r;
        x_b = in_b;
        x_l = in_l;
        case (rot_q)
            2'd1: begin x_t = in_l; x_r = in_t; x_b = in_r; x_l = in_b; end
            2'd2: begin x_t = in_b; x_r = in_l; x_b = in_t; x_l = in_r; end
            2'd3: begin x_t = in_r; x_r = in_b; x_b = in_l; x_l = in_t; end
            default: ;
        endcase
    end

    assign t_out  = ~(x_r & x_b);
    assign rb_out = x_l;
    assign l_out  = pipe_q[NBITS-1 -: WIDTH];

    always_comb begin
        out_t = t_out;
        out_r = rb_out;
        out_b = rb_out;
        out_l = l_out;
        case (rot_q)
            2'd1: begin out_t = rb_out; out_r = rb_out; out_b = l_out;  out_l = t_out;  end
            2'd2: begin out_t = rb_out; out_r = l_out;  out_b = t_out;  out_l = rb_out; end
            2'd3: begin out_t = l_out;  out_r = t_out;  out_b = rb_out; out_l = rb_out; end
            default: ;
        endcase
    end

    assign normal_d[WIDTH-1:0] = en_i ? in_i : x_t;

    for (genvar gi = 1; gi < DEPTH; gi++) begin : g_stage
        assign normal_d[gi*WIDTH +: WIDTH] = pipe_q[(gi-1)*WIDTH +: WIDTH];
    end

`ifdef ROT_CELL_WIDE_SCAN_EN
    logic [NBITS-1:0] shift_d;

    // The flattened pipeline vector is already in chain order: stage[0] bit 0 first.
    if (NBITS == 1) begin : g_shift_one
        assign shift_d = scan_in;
    end else begin : g_shift_many
        assign shift_d = {pipe_q[NBITS-2:0], scan_in};
    end

    assign scan_out = pipe_q[NBITS-1];

    always_comb begin
        pipe_d = scan_en ? shift_d : normal_d;
    end
`else
    always_comb begin
        pipe_d = normal_d;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pipe_q <= '0;
        else
            pipe_q <= pipe_d;
    end

    assign out_o = l_out;
    assign rot_o = rot_q;

endmodule

// File: tb/tb_rot_cell_wide.sv
// Directed scoreboard bench for rot_cell_wide (WIDTH=4, DEPTH=2).
module tb_rot_cell_wide;

    localparam int W = 4;
    localparam int D = 2;

    logic         clk = 1'b0;
    logic         rst, trig, load, en_i;
    logic [1:0]   load_rot;
    logic [W-1:0] in_t, in_r, in_b, in_l, in_i;
    logic [W-1:0] out_t, out_r, out_b, out_l, out_o;
    logic [1:0]   rot_o;
`ifdef ROT_CELL_WIDE_SCAN_EN
    logic         scan_en, scan_in, scan_out;
`endif

    always #5 clk = ~clk;

    rot_cell_wide #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .trig(trig), .load(load), .load_rot(load_rot),
        .in_t(in_t), .in_r(in_r), .in_b(in_b), .in_l(in_l),
        .in_i(in_i), .en_i(en_i),
`ifdef ROT_CELL_WIDE_SCAN_EN
        .scan_en(scan_en), .scan_in(scan_in), .scan_out(scan_out),
`endif
        .out_t(out_t), .out_r(out_r), .out_b(out_b), .out_l(out_l),
        .out_o(out_o), .rot_o(rot_o)
    );

    // sel: 0 out_t, 1 out_r, 2 out_b, 3 out_l, 4 out_o, 5 rot_o, 6 scan_out
    typedef struct {
        int         sel;
        logic [3:0] exp;
        int         tag;
    } exp_t;

    exp_t expq[$];
    event sample_ev;
    int   num_checks = 0;
    int   num_errors = 0;
    int   tag_cnt = 0;

    function automatic logic [3:0] observe(input int sel);
        case (sel)
            0: return out_t;
            1: return out_r;
            2: return out_b;
            3: return out_l;
            4: return out_o;
            5: return {2'b00, rot_o};
`ifdef ROT_CELL_WIDE_SCAN_EN
            6: return {3'b000, scan_out};
`endif
            default: return 4'hx;
        endcase
    endfunction

    function automatic string sel_name(input int sel);
        case (sel)
            0: return "out_t";
            1: return "out_r";
            2: return "out_b";
            3: return "out_l";
            4: return "out_o";
            5: return "rot_o";
            6: return "scan_out";
            default: return "unknown";
        endcase
    endfunction

    // Monitor: drains every queued expectation at each sample strobe.
    initial begin
        exp_t       e;
        logic [3:0] act;
        forever begin
            @(sample_ev);
            while (expq.size() > 0) begin
                e   = expq.pop_front();
                act = observe(e.sel);
                num_checks++;
                if (act !== e.exp) begin
                    num_errors++;
                    $display("FAIL check%0d %s: got %h expected %h", e.tag, sel_name(e.sel), act, e.exp);
                end else begin
                    $display("ok   check%0d %s = %h", e.tag, sel_name(e.sel), act);
                end
            end
        end
    end

    task automatic expect_val(input int sel, input logic [3:0] v);
        exp_t e;
        e.sel = sel;
        e.exp = v;
        e.tag = tag_cnt++;
        expq.push_back(e);
    endtask

    task automatic sample();
        #1;
        -> sample_ev;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        in_t = '0; in_r = '0; in_b = '0; in_l = '0;
    endtask

    initial begin
        logic [7:0] scan_seq;
        rst = 1'b1; trig = 1'b0; load = 1'b0; load_rot = 2'd0;
        en_i = 1'b0; in_i = '0;
        clear_inputs();
`ifdef ROT_CELL_WIDE_SCAN_EN
        scan_en = 1'b0; scan_in = 1'b0;
`endif
        scan_seq = 8'b10110001;

        // Reset state before any clock edge.
        #1;
        expect_val(5, 4'h0);
        expect_val(3, 4'h0);
        expect_val(4, 4'h0);
        sample();
        rst = 1'b0;
        step();

        // Upright function at r=0.
        in_l = 4'hA;
        expect_val(1, 4'hA);
        expect_val(2, 4'hA);
        in_r = 4'hC; in_b = 4'hA;
        expect_val(0, 4'h7);
        expect_val(3, 4'h0);
        sample();
        clear_inputs();

        // Step to r=1 and check the rotated routing.
        trig = 1'b1; step(); trig = 1'b0;
        expect_val(5, 4'h1);
        in_t = 4'h3; in_r = 4'h6; in_b = 4'h5; in_l = 4'h0;
        expect_val(0, 4'h5);
        expect_val(1, 4'h5);
        expect_val(2, 4'h0);
        expect_val(3, 4'hD);
        sample();
        clear_inputs();
        trig = 1'b1; step(); trig = 1'b0;
        expect_val(5, 4'h2);
        sample();
        trig = 1'b1; step(); trig = 1'b0;
        expect_val(5, 4'h3);
        sample();
        trig = 1'b1; step(); trig = 1'b0;
        expect_val(5, 4'h0);
        sample();

        // Two-cycle latency from x_t to out_l / out_o.
        in_r = 4'hF; in_b = 4'hF; in_t = 4'h9;
        expect_val(0, 4'h0);
        sample();
        step();
        expect_val(3, 4'h0);
        expect_val(4, 4'h0);
        sample();
        step();
        expect_val(3, 4'h9);
        expect_val(4, 4'h9);
        sample();
        clear_inputs();

        // load beats trig; en_i path independent of rotation.
        load = 1'b1; load_rot = 2'd2; trig = 1'b1;
        en_i = 1'b1; in_i = 4'h3;
        step();
        load = 1'b0; trig = 1'b0;
        expect_val(5, 4'h2);
        expect_val(4, 4'h9);
        sample();
        step();
        expect_val(4, 4'h3);
        expect_val(1, 4'h3);
        expect_val(3, 4'h0);
        sample();

        // Fill with F, then assert reset between edges.
        in_i = 4'hF;
        step();
        step();
        expect_val(4, 4'hF);
        sample();
        rst = 1'b1;
        expect_val(4, 4'h0);
        expect_val(5, 4'h0);
        expect_val(2, 4'h0);
        sample();
        rst = 1'b0;
        en_i = 1'b0; in_i = '0;

`ifdef ROT_CELL_WIDE_SCAN_EN
        // Chain starts cleared; the first shifted bit emerges after 8 shifts.
        scan_en = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            scan_in = scan_seq[8-n];
            step();
            expect_val(6, (n == 8) ? {3'b000, scan_seq[7]} : 4'h0);
            sample();
        end
        scan_en = 1'b0;
`endif

        -> sample_ev;
        #1;
        for (int i = 0; i < 100 && expq.size() > 0; i++) #1;
        if (expq.size() > 0) begin
            num_errors++;
            $display("FAIL drain: %0d pending expectations, required 0", expq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
